// File: rtl/adc_frame_writer.sv
// adc_frame_writer: pairs one EMG and one ECG ADC sample into a frame and
// writes both words into their own circular buffer in the shared data RAM
// with a single-cycle write strobe.
// Build option: define ADC_WR_TAG_EN to place the low bits of the pre-increment
// frame count above each sample, so software can spot stale or torn rings.
module adc_frame_writer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned SAMPLE_WIDTH  = 12,
  parameter int unsigned EMG_BASE      = 2048,
  parameter int unsigned ECG_BASE      = 3072,
  parameter int unsigned BUF_LEN       = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     emg_valid,
  input  logic [SAMPLE_WIDTH-1:0]  emg_sample,
  input  logic                     ecg_valid,
  input  logic [SAMPLE_WIDTH-1:0]  ecg_sample,
  input  logic                     clr_overrun,
  output logic                     adc_wEn,
  output logic [ADDRESS_WIDTH-1:0] adc_addr_emg,
  output logic [DATA_WIDTH-1:0]    adc_dataIn_emg,
  output logic [ADDRESS_WIDTH-1:0] adc_addr_ecg,
  output logic [DATA_WIDTH-1:0]    adc_dataIn_ecg,
  output logic [ADDRESS_WIDTH-1:0] wr_idx,
  output logic [31:0]              frame_cnt,
  output logic                     emg_overrun,
  output logic                     ecg_overrun
);

  localparam int unsigned PAD_WIDTH = DATA_WIDTH - SAMPLE_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] EMG_BASE_A = ADDRESS_WIDTH'(EMG_BASE);
  localparam logic [ADDRESS_WIDTH-1:0] ECG_BASE_A = ADDRESS_WIDTH'(ECG_BASE);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX   = ADDRESS_WIDTH'(BUF_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t                  state;
  logic                    have_emg;
  logic                    have_ecg;
  logic [SAMPLE_WIDTH-1:0] emg_q;
  logic [SAMPLE_WIDTH-1:0] ecg_q;

  logic [DATA_WIDTH-1:0]    emg_word_c;
  logic [DATA_WIDTH-1:0]    ecg_word_c;
  logic [ADDRESS_WIDTH-1:0] wr_idx_next_c;

  // RAM words built from the held samples; the tag is the count before this frame's increment
`ifdef ADC_WR_TAG_EN
  assign emg_word_c = {frame_cnt[PAD_WIDTH-1:0], emg_q};
  assign ecg_word_c = {frame_cnt[PAD_WIDTH-1:0], ecg_q};
`else
  assign emg_word_c = {{PAD_WIDTH{1'b0}}, emg_q};
  assign ecg_word_c = {{PAD_WIDTH{1'b0}}, ecg_q};
`endif

  // Ring slot after the current one
  assign wr_idx_next_c = (wr_idx == LAST_IDX) ? '0 : wr_idx + ADDRESS_WIDTH'(1);

  // Frame FSM: collect both samples, strobe one write, advance the ring slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      have_emg       <= 1'b0;
      have_ecg       <= 1'b0;
      emg_q          <= '0;
      ecg_q          <= '0;
      adc_wEn        <= 1'b0;
      adc_addr_emg   <= '0;
      adc_addr_ecg   <= '0;
      adc_dataIn_emg <= '0;
      adc_dataIn_ecg <= '0;
      wr_idx         <= '0;
      frame_cnt      <= '0;
      emg_overrun    <= 1'b0;
      ecg_overrun    <= 1'b0;
    end else begin
      // Clear first so a coincident overrun set below takes priority
      if (clr_overrun) begin
        emg_overrun <= 1'b0;
        ecg_overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          have_emg <= 1'b0;
          have_ecg <= 1'b0;
          if (enable) state <= COLLECT;
        end

        COLLECT: begin
          if (!enable) begin
            have_emg <= 1'b0;
            have_ecg <= 1'b0;
            state    <= IDLE;
          end else if (have_emg && have_ecg) begin
            state          <= WRITE;
            adc_wEn        <= 1'b1;
            adc_addr_emg   <= EMG_BASE_A + wr_idx;
            adc_addr_ecg   <= ECG_BASE_A + wr_idx;
            adc_dataIn_emg <= emg_word_c;
            adc_dataIn_ecg <= ecg_word_c;
            // Flags restart for the next frame; a sample arriving now belongs to it
            have_emg <= emg_valid;
            have_ecg <= ecg_valid;
            if (emg_valid) emg_q <= emg_sample;
            if (ecg_valid) ecg_q <= ecg_sample;
          end else begin
            if (emg_valid) begin
              emg_q    <= emg_sample;
              have_emg <= 1'b1;
              if (have_emg) emg_overrun <= 1'b1;
            end
            if (ecg_valid) begin
              ecg_q    <= ecg_sample;
              have_ecg <= 1'b1;
              if (have_ecg) ecg_overrun <= 1'b1;
            end
          end
        end

        WRITE: begin
          adc_wEn   <= 1'b0;
          wr_idx    <= wr_idx_next_c;
          frame_cnt <= frame_cnt + 32'd1;
          if (!enable) begin
            have_emg <= 1'b0;
            have_ecg <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= COLLECT;
            if (emg_valid) begin
              emg_q    <= emg_sample;
              have_emg <= 1'b1;
              if (have_emg) emg_overrun <= 1'b1;
            end
            if (ecg_valid) begin
              ecg_q    <= ecg_sample;
              have_ecg <= 1'b1;
              if (have_ecg) ecg_overrun <= 1'b1;
            end
          end
        end

        default: begin
          adc_wEn  <= 1'b0;
          have_emg <= 1'b0;
          have_ecg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_writer.sv
// Directed bench for adc_frame_writer (default parameters; follows ADC_WR_TAG_EN).
`timescale 1ns/1ps
module tb_adc_frame_writer;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 12;
  localparam int unsigned SW    = 12;
  localparam int unsigned EMG_B = 2048;
  localparam int unsigned ECG_B = 3072;
  localparam int unsigned BL    = 1024;
`ifdef ADC_WR_TAG_EN
  localparam logic [31:0] TAG_MASK = 32'h000F_FFFF;
`else
  localparam logic [31:0] TAG_MASK = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          emg_valid;
  logic [SW-1:0] emg_sample;
  logic          ecg_valid;
  logic [SW-1:0] ecg_sample;
  logic          clr_overrun;
  logic          adc_wEn;
  logic [AW-1:0] adc_addr_emg;
  logic [DW-1:0] adc_dataIn_emg;
  logic [AW-1:0] adc_addr_ecg;
  logic [DW-1:0] adc_dataIn_ecg;
  logic [AW-1:0] wr_idx;
  logic [31:0]   frame_cnt;
  logic          emg_overrun;
  logic          ecg_overrun;

  int          n_vec   = 0;
  int          n_err   = 0;
  int          wen_cnt = 0;
  int unsigned exp_idx = 0;
  int unsigned exp_cnt = 0;
  int          w0;

  adc_frame_writer dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .emg_valid      (emg_valid),
    .emg_sample     (emg_sample),
    .ecg_valid      (ecg_valid),
    .ecg_sample     (ecg_sample),
    .clr_overrun    (clr_overrun),
    .adc_wEn        (adc_wEn),
    .adc_addr_emg   (adc_addr_emg),
    .adc_dataIn_emg (adc_dataIn_emg),
    .adc_addr_ecg   (adc_addr_ecg),
    .adc_dataIn_ecg (adc_dataIn_ecg),
    .wr_idx         (wr_idx),
    .frame_cnt      (frame_cnt),
    .emg_overrun    (emg_overrun),
    .ecg_overrun    (ecg_overrun)
  );

  always #5 clk = ~clk;

  // Count write-strobe cycles, sampled mid-cycle
  always @(negedge clk) if (adc_wEn) wen_cnt = wen_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [SW-1:0] s, input int unsigned cnt);
    logic [31:0] c;
    c = 32'(cnt) & TAG_MASK;
    exp_word = {c[19:0], s};
  endfunction

  // Called in the WRITE cycle; checks the strobe and payload, then the exit edge
  task automatic expect_frame(input string tag, input logic [SW-1:0] e, input logic [SW-1:0] c);
    chk({tag, ".wEn"},      64'(adc_wEn),        64'(1));
    chk({tag, ".addr_emg"}, 64'(adc_addr_emg),   64'(EMG_B + exp_idx));
    chk({tag, ".addr_ecg"}, 64'(adc_addr_ecg),   64'(ECG_B + exp_idx));
    chk({tag, ".data_emg"}, 64'(adc_dataIn_emg), 64'(exp_word(e, exp_cnt)));
    chk({tag, ".data_ecg"}, 64'(adc_dataIn_ecg), 64'(exp_word(c, exp_cnt)));
    step();
    exp_idx = (exp_idx + 1) % BL;
    exp_cnt = exp_cnt + 1;
    chk({tag, ".wEn_off"},   64'(adc_wEn),   64'(0));
    chk({tag, ".wr_idx"},    64'(wr_idx),    64'(exp_idx));
    chk({tag, ".frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".wEn"},       64'(adc_wEn),        64'(0));
    chk({tag, ".addr_emg"},  64'(adc_addr_emg),   64'(0));
    chk({tag, ".addr_ecg"},  64'(adc_addr_ecg),   64'(0));
    chk({tag, ".data_emg"},  64'(adc_dataIn_emg), 64'(0));
    chk({tag, ".data_ecg"},  64'(adc_dataIn_ecg), 64'(0));
    chk({tag, ".wr_idx"},    64'(wr_idx),         64'(0));
    chk({tag, ".frame_cnt"}, 64'(frame_cnt),      64'(0));
    chk({tag, ".emg_ovr"},   64'(emg_overrun),    64'(0));
    chk({tag, ".ecg_ovr"},   64'(ecg_overrun),    64'(0));
  endtask

  task automatic emg_in(input logic [SW-1:0] s);
    emg_valid = 1'b1; emg_sample = s; step(); emg_valid = 1'b0;
  endtask

  task automatic ecg_in(input logic [SW-1:0] s);
    ecg_valid = 1'b1; ecg_sample = s; step(); ecg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; emg_valid = 1'b0; ecg_valid = 1'b0;
    emg_sample = '0; ecg_sample = '0; clr_overrun = 1'b0;
    step(); step();
    check_all_zero("rst");
    reset = 1'b0;
    step();                                   // IDLE -> COLLECT

    // 1: first frame, samples on different edges
    emg_in(12'h123);
    ecg_in(12'h456);
    step();                                   // both flags seen -> WRITE
    expect_frame("t1", 12'h123, 12'h456);
    chk("t1.pulses", 64'(wen_cnt), 64'(1));
    chk("t1.hold_emg", 64'(adc_dataIn_emg), 64'(exp_word(12'h123, 0)));

    // 2: a full ring plus one, simultaneous pairs, wrap from 1023 to 0
    for (int i = 0; i < 1024; i++) begin
      emg_valid = 1'b1; ecg_valid = 1'b1;
      emg_sample = SW'(i); ecg_sample = SW'(12'hFFF - i);
      step();
      emg_valid = 1'b0; ecg_valid = 1'b0;
      step();
      expect_frame("t2", SW'(i), SW'(12'hFFF - i));
    end
    chk("t2.idx_end", 64'(wr_idx), 64'(1));
    chk("t2.cnt_end", 64'(frame_cnt), 64'(1025));
    chk("t2.no_ovr", 64'(emg_overrun), 64'(0));

    // 3: overrun, sticky flag, clear, set-wins-over-clear
    emg_in(12'h001);
    emg_in(12'h002);
    chk("t3.emg_ovr", 64'(emg_overrun), 64'(1));
    chk("t3.ecg_ovr", 64'(ecg_overrun), 64'(0));
    ecg_in(12'h003);
    step();
    expect_frame("t3a", 12'h002, 12'h003);
    chk("t3.sticky", 64'(emg_overrun), 64'(1));
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk("t3.cleared", 64'(emg_overrun), 64'(0));
    emg_in(12'h005);
    clr_overrun = 1'b1;
    emg_in(12'h006);
    clr_overrun = 1'b0;
    chk("t3.set_wins", 64'(emg_overrun), 64'(1));
    ecg_in(12'h007);
    step();
    expect_frame("t3b", 12'h006, 12'h007);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk("t3.cleared2", 64'(emg_overrun), 64'(0));

    // 4: partial frame discarded when enable drops
    emg_in(12'h0AA);
    enable = 1'b0; step();                    // discard, go IDLE
    w0 = wen_cnt;
    enable = 1'b1; step();                    // IDLE -> COLLECT
    ecg_in(12'h0BB);
    step();
    chk("t4.no_write", 64'(adc_wEn), 64'(0));
    step();
    chk("t4.pulses", 64'(wen_cnt - w0), 64'(0));
    emg_in(12'h0CC);
    step();
    expect_frame("t4", 12'h0CC, 12'h0BB);

    // 5: both valids on one edge, new EMG on the WRITE entry edge
    emg_valid = 1'b1; ecg_valid = 1'b1; emg_sample = 12'h111; ecg_sample = 12'h222;
    step();
    ecg_valid = 1'b0; emg_sample = 12'h333;   // arrives on the WRITE entry edge
    step();
    emg_valid = 1'b0;
    expect_frame("t5a", 12'h111, 12'h222);
    chk("t5.emg_ovr", 64'(emg_overrun), 64'(0));
    chk("t5.ecg_ovr", 64'(ecg_overrun), 64'(0));
    ecg_in(12'h444);
    step();
    enable = 1'b0;                            // drops during WRITE: write still completes
    expect_frame("t5b", 12'h333, 12'h444);
    w0 = wen_cnt;
    emg_valid = 1'b1; ecg_valid = 1'b1; step();
    emg_valid = 1'b0; ecg_valid = 1'b0;
    step(); step();
    chk("t5.idle_ignore", 64'(wen_cnt - w0), 64'(0));
    chk("t5.idle_idx", 64'(wr_idx), 64'(exp_idx));
    enable = 1'b1; step();

    // 6: async reset in the middle of a WRITE, then tagged frame 5
    emg_valid = 1'b1; ecg_valid = 1'b1; emg_sample = 12'h0AB; ecg_sample = 12'h0BA;
    step();
    emg_valid = 1'b0; ecg_valid = 1'b0;
    step();
    chk("t6.in_write", 64'(adc_wEn), 64'(1));
    #2 reset = 1'b1;
    #1 check_all_zero("t6.async");
    step();
    reset = 1'b0;
    exp_idx = 0; exp_cnt = 0;
    step();                                   // IDLE -> COLLECT
    for (int i = 0; i < 6; i++) begin
      emg_valid = 1'b1; ecg_valid = 1'b1;
      emg_sample = (i == 5) ? 12'h7FF : SW'(12'h010 + i);
      ecg_sample = (i == 5) ? 12'h7FF : SW'(12'h020 + i);
      step();
      emg_valid = 1'b0; ecg_valid = 1'b0;
      step();
      if (i == 5) begin
`ifdef ADC_WR_TAG_EN
        chk("t6.tag5", 64'(adc_dataIn_emg), 64'h0000_57FF);
`else
        chk("t6.tag5", 64'(adc_dataIn_emg), 64'h0000_07FF);
`endif
      end
      expect_frame("t6", emg_sample, ecg_sample);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
